// File: rtl/perf_pkg.sv
// perf_pkg: shared constants for the performance-counter block.
//   DEFAULT_WIDTH  default counter / MMIO data width
//   OFF_*          byte offsets of the counter registers from MMIO_BASE
//   WINDOW_BYTES   size of the decoded MMIO window
package perf_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned ADDR_W        = 32;

  localparam logic [ADDR_W-1:0] OFF_CYCLE      = 32'h00;
  localparam logic [ADDR_W-1:0] OFF_INSTR      = 32'h04;
  localparam logic [ADDR_W-1:0] OFF_CLEAR      = 32'h08;
  localparam logic [ADDR_W-1:0] OFF_BR_TOTAL   = 32'h0C;
  localparam logic [ADDR_W-1:0] OFF_BR_CORRECT = 32'h10;
  localparam logic [ADDR_W-1:0] OFF_SNAP       = 32'h14;
  localparam logic [ADDR_W-1:0] WINDOW_BYTES   = 32'h18;

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: WIDTH-bit wrapping event counter.
//   clk    system clock
//   rst    synchronous active-high reset
//   inc    count one event this cycle
//   clr    zero the counter; wins over inc
//   count  current count (registered)
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Wraps modulo 2^WIDTH without a flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: cycle / retired-instruction / branch performance counters
// with an MMIO read/clear interface.
//   clk, rst               system clock, synchronous active-high reset
//   retire_*               retire-stage event qualifiers
//   mmio_addr/re/we        MMIO load/store request from the memory stage
//   mmio_rdata/rvalid      load response, one cycle after mmio_re
//   cycle_counter          live cycle count
//   instruction_counter    live retired-instruction count
// Optional build macro PERF_SNAPSHOT_EN: a store to OFF_SNAP latches all four
// counters into shadows, and counter reads return the shadows.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 32'h8000_0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire_valid,
  input  logic              retire_is_branch,
  input  logic              retire_mispredict,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic              mmio_re,
  input  logic              mmio_we,
  output logic [WIDTH-1:0]  mmio_rdata,
  output logic              mmio_rvalid,
  output logic [WIDTH-1:0]  cycle_counter,
  output logic [WIDTH-1:0]  instruction_counter
);

  logic [ADDR_W-1:0] offset;
  logic              in_window;
  logic              clr;
  logic              br_retire;
  logic [WIDTH-1:0]  br_total;
  logic [WIDTH-1:0]  br_correct;
  logic [WIDTH-1:0]  rd_cycle, rd_instr, rd_br_total, rd_br_correct;
  logic [WIDTH-1:0]  rd_mux;

  // Addresses below the base wrap to a huge offset, so one compare bounds both ends.
  assign offset    = mmio_addr - MMIO_BASE;
  assign in_window = (offset < WINDOW_BYTES);
  assign clr       = mmio_we && in_window && (offset == OFF_CLEAR);
  assign br_retire = retire_valid && retire_is_branch;

  perf_counter_cell #(.WIDTH(WIDTH)) u_cycle (
    .clk(clk), .rst(rst), .inc(1'b1), .clr(clr), .count(cycle_counter)
  );

  perf_counter_cell #(.WIDTH(WIDTH)) u_instr (
    .clk(clk), .rst(rst), .inc(retire_valid), .clr(clr), .count(instruction_counter)
  );

  perf_counter_cell #(.WIDTH(WIDTH)) u_br_total (
    .clk(clk), .rst(rst), .inc(br_retire), .clr(clr), .count(br_total)
  );

  perf_counter_cell #(.WIDTH(WIDTH)) u_br_correct (
    .clk(clk), .rst(rst), .inc(br_retire && !retire_mispredict), .clr(clr),
    .count(br_correct)
  );

`ifdef PERF_SNAPSHOT_EN
  logic             snap_we;
  logic [WIDTH-1:0] snap_cycle, snap_instr, snap_br_total, snap_br_correct;

  assign snap_we = mmio_we && in_window && (offset == OFF_SNAP);

  // Shadows capture the pre-edge counts and are untouched by counter clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cycle      <= '0;
      snap_instr      <= '0;
      snap_br_total   <= '0;
      snap_br_correct <= '0;
    end else if (snap_we) begin
      snap_cycle      <= cycle_counter;
      snap_instr      <= instruction_counter;
      snap_br_total   <= br_total;
      snap_br_correct <= br_correct;
    end
  end

  assign rd_cycle      = snap_cycle;
  assign rd_instr      = snap_instr;
  assign rd_br_total   = snap_br_total;
  assign rd_br_correct = snap_br_correct;
`else
  assign rd_cycle      = cycle_counter;
  assign rd_instr      = instruction_counter;
  assign rd_br_total   = br_total;
  assign rd_br_correct = br_correct;
`endif

  // Read decode; write-only and unmapped offsets read as zero.
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_CYCLE:      rd_mux = rd_cycle;
      OFF_INSTR:      rd_mux = rd_instr;
      OFF_BR_TOTAL:   rd_mux = rd_br_total;
      OFF_BR_CORRECT: rd_mux = rd_br_correct;
      default:        rd_mux = '0;
    endcase
  end

  // Read response register: samples pre-edge counts, one-cycle rvalid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_rdata  <= '0;
      mmio_rvalid <= 1'b0;
    end else begin
      mmio_rvalid <= mmio_re && in_window;
      if (mmio_re && in_window) begin
        mmio_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: directed self-checking bench for perf_counter_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_perf_counter_unit;

  localparam int unsigned W    = 32;
  localparam logic [31:0] BASE = 32'h8000_0010;

  logic          clk = 1'b0;
  logic          rst;
  logic          retire_valid, retire_is_branch, retire_mispredict;
  logic [31:0]   mmio_addr;
  logic          mmio_re, mmio_we;
  logic [W-1:0]  mmio_rdata;
  logic          mmio_rvalid;
  logic [W-1:0]  cycle_counter, instruction_counter;

  int checks = 0;
  int errors = 0;

  perf_counter_unit #(.WIDTH(W), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .retire_valid(retire_valid), .retire_is_branch(retire_is_branch),
    .retire_mispredict(retire_mispredict),
    .mmio_addr(mmio_addr), .mmio_re(mmio_re), .mmio_we(mmio_we),
    .mmio_rdata(mmio_rdata), .mmio_rvalid(mmio_rvalid),
    .cycle_counter(cycle_counter), .instruction_counter(instruction_counter)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    retire_valid = 1'b0; retire_is_branch = 1'b0; retire_mispredict = 1'b0;
    mmio_re = 1'b0; mmio_we = 1'b0; mmio_addr = BASE;
  endtask

  task automatic do_clear();
    mmio_addr = BASE + 32'h08; mmio_we = 1'b1;
    tick();
    mmio_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (10) tick();
    checks++; if (cycle_counter !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cycle_counter); end
    checks++; if (instruction_counter !== 32'd0) begin errors++; $display("FAIL reset_instr: got %0d expected 0", instruction_counter); end
    checks++; if (mmio_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", mmio_rvalid); end
    checks++; if (mmio_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", mmio_rdata); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      retire_valid = (i < 60);
      tick();
    end
    idle();
    checks++; if (cycle_counter !== 32'd100) begin errors++; $display("FAIL run_cycle: got %0d expected 100", cycle_counter); end
    checks++; if (instruction_counter !== 32'd60) begin errors++; $display("FAIL run_instr: got %0d expected 60", instruction_counter); end
    mmio_re = 1'b1; mmio_addr = BASE + 32'h0C;
    tick();
    checks++; if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL run_br_total: got %0d/%b expected 0/1", mmio_rdata, mmio_rvalid); end
    mmio_addr = BASE + 32'h10;
    tick();
    checks++; if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL run_br_correct: got %0d/%b expected 0/1", mmio_rdata, mmio_rvalid); end
    idle();
    tick();
  endtask

  task automatic test_branches();
    idle();
    do_clear();
    // 20 branches, mispredicts at i = 0,4,8,12,16
    for (int i = 0; i < 20; i++) begin
      retire_valid = 1'b1; retire_is_branch = 1'b1; retire_mispredict = (i % 4 == 0);
      tick();
    end
    // non-branch instructions with a stray mispredict: instructions only
    for (int i = 0; i < 3; i++) begin
      retire_valid = 1'b1; retire_is_branch = 1'b0; retire_mispredict = 1'b1;
      tick();
    end
    // unqualified branch bubble: nothing counted
    retire_valid = 1'b0; retire_is_branch = 1'b1; retire_mispredict = 1'b1;
    tick();
    idle();
    checks++; if (instruction_counter !== 32'd23) begin errors++; $display("FAIL br_instr: got %0d expected 23", instruction_counter); end
  endtask

  task automatic test_back_to_back();
    mmio_re = 1'b1; mmio_addr = BASE + 32'h0C;
    tick();
    checks++; if (mmio_rdata !== 32'd20 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_br_total: got %0d/%b expected 20/1", mmio_rdata, mmio_rvalid); end
    mmio_addr = BASE + 32'h10;
    tick();
    checks++; if (mmio_rdata !== 32'd15 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_br_correct: got %0d/%b expected 15/1", mmio_rdata, mmio_rvalid); end
    mmio_addr = BASE + 32'h04;
    tick();
    checks++; if (mmio_rdata !== 32'd23 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_instr: got %0d/%b expected 23/1", mmio_rdata, mmio_rvalid); end
    mmio_re = 1'b0;
    tick();
    checks++; if (mmio_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_drop: got %b expected 0", mmio_rvalid); end
  endtask

  task automatic test_wrap();
    idle();
    do_clear();
    force dut.u_instr.count = 32'hFFFF_FFFF;
    tick();
    release dut.u_instr.count;
    checks++; if (instruction_counter !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %0h expected ffffffff", instruction_counter); end
    retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0;
    checks++; if (instruction_counter !== 32'd0) begin errors++; $display("FAIL wrap_instr: got %0h expected 0", instruction_counter); end
    checks++; if (cycle_counter !== 32'd2) begin errors++; $display("FAIL wrap_cycle: got %0d expected 2", cycle_counter); end
    mmio_re = 1'b1; mmio_addr = BASE + 32'h0C;
    tick();
    mmio_re = 1'b0;
    checks++; if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL wrap_br_total: got %0d/%b expected 0/1", mmio_rdata, mmio_rvalid); end
  endtask

  task automatic test_clear_collision();
    idle();
    do_clear();
    retire_valid = 1'b1;
    repeat (7) tick();
    // read instr while another instruction retires: pre-edge value 7
    mmio_re = 1'b1; mmio_addr = BASE + 32'h04;
    tick();
    mmio_re = 1'b0;
    checks++; if (mmio_rdata !== 32'd7 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL coll_read: got %0d/%b expected 7/1", mmio_rdata, mmio_rvalid); end
    // clear with a retiring instruction on the same edge
    mmio_we = 1'b1; mmio_addr = BASE + 32'h08;
    tick();
    mmio_we = 1'b0; retire_valid = 1'b0;
    checks++; if (instruction_counter !== 32'd0) begin errors++; $display("FAIL coll_instr: got %0d expected 0", instruction_counter); end
    checks++; if (cycle_counter !== 32'd0) begin errors++; $display("FAIL coll_cycle: got %0d expected 0", cycle_counter); end
    checks++; if (mmio_rvalid !== 1'b0) begin errors++; $display("FAIL coll_rvalid_pulse: got %b expected 0", mmio_rvalid); end
    tick();
    checks++; if (cycle_counter !== 32'd1) begin errors++; $display("FAIL coll_resume: got %0d expected 1", cycle_counter); end
    // load and store together at the clear offset
    retire_valid = 1'b1; mmio_re = 1'b1; mmio_we = 1'b1; mmio_addr = BASE + 32'h08;
    tick();
    idle();
    checks++; if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1 || instruction_counter !== 32'd0) begin errors++; $display("FAIL coll_rw: got %0d/%b/%0d expected 0/1/0", mmio_rdata, mmio_rvalid, instruction_counter); end
  endtask

  task automatic test_read_latency();
    idle();
    do_clear();
    repeat (5) tick();
    mmio_re = 1'b1; mmio_addr = BASE;
    tick();
    mmio_re = 1'b0;
    checks++; if (mmio_rdata !== 32'd5 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL lat_read: got %0d/%b expected 5/1", mmio_rdata, mmio_rvalid); end
    checks++; if (cycle_counter !== 32'd6) begin errors++; $display("FAIL lat_cycle: got %0d expected 6", cycle_counter); end
    tick();
    checks++; if (mmio_rvalid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: got %b expected 0", mmio_rvalid); end
    mmio_re = 1'b1; mmio_addr = BASE + 32'h18;
    tick();
    checks++; if (mmio_rvalid !== 1'b0) begin errors++; $display("FAIL oow_above: got %b expected 0", mmio_rvalid); end
    mmio_addr = BASE - 32'h04;
    tick();
    checks++; if (mmio_rvalid !== 1'b0) begin errors++; $display("FAIL oow_below: got %b expected 0", mmio_rvalid); end
    mmio_addr = BASE + 32'h14;
    tick();
    mmio_re = 1'b0;
    checks++; if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL unmapped_read: got %0h/%b expected 0/1", mmio_rdata, mmio_rvalid); end
  endtask

  task automatic test_snapshot();
    logic [31:0] exp_snap_read, exp_after_clear;
`ifdef PERF_SNAPSHOT_EN
    exp_snap_read   = 32'd500;
    exp_after_clear = 32'd500;
`else
    exp_snap_read   = 32'd550;
    exp_after_clear = 32'd0;
`endif
    idle();
    do_clear();
    repeat (500) tick();
    mmio_we = 1'b1; mmio_addr = BASE + 32'h14;
    tick();
    mmio_we = 1'b0;
    repeat (49) tick();
    checks++; if (cycle_counter !== 32'd550) begin errors++; $display("FAIL snap_live: got %0d expected 550", cycle_counter); end
    mmio_re = 1'b1; mmio_addr = BASE;
    tick();
    mmio_re = 1'b0;
    checks++; if (mmio_rdata !== exp_snap_read || mmio_rvalid !== 1'b1) begin errors++; $display("FAIL snap_read: got %0d/%b expected %0d/1", mmio_rdata, mmio_rvalid, exp_snap_read); end
    do_clear();
    mmio_re = 1'b1; mmio_addr = BASE;
    tick();
    mmio_re = 1'b0;
    checks++; if (mmio_rdata !== exp_after_clear) begin errors++; $display("FAIL snap_after_clear: got %0d expected %0d", mmio_rdata, exp_after_clear); end
  endtask

  task automatic test_mid_reset();
    idle();
    repeat (3) tick();
    retire_valid = 1'b1; mmio_re = 1'b1; mmio_addr = BASE; rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++; if (cycle_counter !== 32'd0 || instruction_counter !== 32'd0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d expected 0/0", cycle_counter, instruction_counter); end
    checks++; if (mmio_rvalid !== 1'b0 || mmio_rdata !== 32'd0) begin errors++; $display("FAIL midrst_read: got %0h/%b expected 0/0", mmio_rdata, mmio_rvalid); end
  endtask

  initial begin
    test_reset();
    test_branches();
    test_back_to_back();
    test_wrap();
    test_clear_collision();
    test_read_latency();
    test_snapshot();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
